number_digit_serializer: RTL
============================

NUMBER_DIGIT_SERIALIZER -- requirements
Module: number_digit_serializer

Interface
REQ-001 Parameter: WIDTH, 32, bit width of the signed two's-complement number register value.
REQ-002 Parameter: DIGITS, 10, decimal digit capacity; SHALL satisfy 10^DIGITS > 2^(WIDTH-1).
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to convert `number`; sampled only in IDLE.
REQ-006 number  input  WIDTH  signed value taken from the controller number register.
REQ-007 digit_ready  input  1  consumer accepts the current digit.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 negative  output  1  sign of the captured number, held from capture until the next capture.
REQ-010 digit_valid  output  1  `digit` is presented for transfer.
REQ-011 digit  output  4  BCD digit 0-9, most significant first.
REQ-012 digit_last  output  1  high with digit_valid on the final (least significant) digit.

Function
REQ-013 States SHALL be IDLE, CONVERT, SKIP and EMIT; all transitions occur on rising Clock edges.
REQ-014 IDLE + start=1: capture |number| as a WIDTH-bit unsigned magnitude, set negative=number[WIDTH-1], clear the BCD accumulator (4*DIGITS bits), load the shift counter with WIDTH, go to CONVERT.
REQ-015 Magnitude SHALL be formed modulo 2^WIDTH; -2^(WIDTH-1) SHALL give magnitude 2^(WIDTH-1) with no overflow flag.
REQ-016 CONVERT: each cycle, every BCD nibble >=5 gets +3, then {BCD, magnitude} shifts left 1; the counter decrements; the state goes to SKIP after exactly WIDTH cycles.
REQ-017 SKIP entry loads the remaining-digit count with DIGITS.
REQ-018 SKIP, each cycle: if the top nibble is 0 and count>1, shift BCD left 4 and decrement count; otherwise go to EMIT.
REQ-019 SKIP SHALL last L+1 cycles, where L is the number of suppressed leading zeros.
REQ-020 First digit_valid SHALL rise exactly WIDTH+L+1 edges after the accepting edge.
REQ-021 Value 0 SHALL emit exactly one digit 0.
REQ-022 EMIT: digit_valid=1 and digit=top BCD nibble; digit_last=1 when count==1; digit_valid is 0 in all other states.
REQ-023 EMIT transfer happens on any edge with digit_valid=1 and digit_ready=1.
REQ-024 On a non-last transfer: shift BCD left 4, decrement count, stay in EMIT; next digit valid in the following cycle, with no bubble.
REQ-025 On a last transfer: go to IDLE; busy falls in the next cycle.
REQ-026 Back-pressure: while digit_ready=0, digit, digit_valid and digit_last SHALL hold stable.
REQ-027 start SHALL be ignored while busy=1; `number` changes after capture SHALL not affect output.
REQ-028 start in the same cycle that busy falls (first IDLE cycle) SHALL be accepted normally.

Reset
REQ-029 Reset=0 at a clock edge SHALL force IDLE from any state, including mid-CONVERT and mid-EMIT.
REQ-030 Reset values: busy=0, digit_valid=0, digit=0, digit_last=0, negative=0, accumulators and counters 0.
REQ-031 Reset SHALL take priority over start and digit_ready in the same cycle.
REQ-032 After reset releases, an in-flight digit SHALL not resume.

Verification
REQ-033 number=0, start, digit_ready=1 -> after 42 edges, a single digit 0 with digit_last=1, negative=0; busy falls next cycle.
REQ-034 number=12345, digit_ready=1 -> digits 1,2,3,4,5 on consecutive cycles, last on 5; first valid 38 edges after accept.
REQ-035 number=-2147483648 -> negative=1; digits 2,1,4,7,4,8,3,6,4,8; first valid 33 edges after accept.
REQ-036 number=-7, digit_ready=0 for 5 cycles then 1 -> digit 7 with digit_last=1 held stable for 5 cycles, transferred on the first ready cycle.
REQ-037 number=907; start pulsed with number=55 during CONVERT -> output stays 9,0,7; start re-issued in the first IDLE cycle -> 5,5.
REQ-038 Reset=0 asserted during EMIT of 12345 after digit 2 -> next cycle busy=0, digit_valid=0, negative=0; no further digits.

Source files
------------

// File: rtl/number_digit_serializer.sv
// Converts a signed binary number to BCD by double-dabble, then streams the
// decimal digits most-significant first with leading zeros suppressed.
module number_digit_serializer #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic [WIDTH-1:0] number,
    input  logic             digit_ready,
    output logic             busy,
    output logic             negative,
    output logic             digit_valid,
    output logic [3:0]       digit,
    output logic             digit_last
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SC_W  = $clog2(WIDTH + 1);
    localparam int DC_W  = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {IDLE, CONVERT, SKIP, EMIT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [SC_W-1:0]  shift_cnt_q, shift_cnt_d;
    logic [DC_W-1:0]  dig_cnt_q, dig_cnt_d;
    logic             negative_q, negative_d;

    // Double-dabble correction: any nibble that would reach >=10 after the shift gets +3.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            bcd_q       <= '0;
            shift_cnt_q <= '0;
            dig_cnt_q   <= '0;
            negative_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            bcd_q       <= bcd_d;
            shift_cnt_q <= shift_cnt_d;
            dig_cnt_q   <= dig_cnt_d;
            negative_q  <= negative_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        bcd_d       = bcd_q;
        shift_cnt_d = shift_cnt_q;
        dig_cnt_d   = dig_cnt_q;
        negative_d  = negative_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Two's-complement negate wraps, so the most negative value maps to 2^(WIDTH-1).
                    mag_d       = number[WIDTH-1] ? (~number + WIDTH'(1)) : number;
                    negative_d  = number[WIDTH-1];
                    bcd_d       = '0;
                    shift_cnt_d = SC_W'(WIDTH);
                    state_d     = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, mag_d} = {dabble_adjust(bcd_q), mag_q} << 1;
                shift_cnt_d    = shift_cnt_q - SC_W'(1);
                if (shift_cnt_q == SC_W'(1)) begin
                    dig_cnt_d = DC_W'(DIGITS);
                    state_d   = SKIP;
                end
            end
            SKIP: begin
                if (bcd_q[BCD_W-1 -: 4] == 4'd0 && dig_cnt_q > DC_W'(1)) begin
                    bcd_d     = bcd_q << 4;
                    dig_cnt_d = dig_cnt_q - DC_W'(1);
                end else begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (digit_ready) begin
                    if (dig_cnt_q == DC_W'(1)) begin
                        state_d = IDLE;
                    end else begin
                        bcd_d     = bcd_q << 4;
                        dig_cnt_d = dig_cnt_q - DC_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign negative    = negative_q;
    assign digit_valid = (state_q == EMIT);
    assign digit       = digit_valid ? bcd_q[BCD_W-1 -: 4] : 4'd0;
    assign digit_last  = digit_valid && (dig_cnt_q == DC_W'(1));

endmodule
